display_source_scheduler: RTL and testbench
===========================================

// Module: display_source_scheduler
// PURPOSE
//  Time-shares the 4-digit seven-segment display subsystem between three requesters:
//  src0 = stopwatch, src1 = ADC readout, src2 = alarm.
//  Arbitrates per-source requests using round-robin with a minimum dwell time; src2 may preempt.
//  Drives the subsystem's digit, decimal-point and triangle_en inputs from the owner's data.
//  Sits between the timekeeping/measurement logic and seven_segment_display_subsystem.
// PARAMETERS
//  DWELL_CYCLES  100_000_000  min cycles an owner keeps the display while others wait (>=2)
//  PREEMPT_EN    1            1: src2 request preempts any owner immediately; 0: src2 is round-robin only
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  req            in   3   per-source display request, level, bit i = src i
//  src0_digits    in   16  src0 nibbles {min_dig2,min_dig1,sec_dig2,sec_dig1}
//  src1_digits    in   16  src1 nibbles, same packing
//  src2_digits    in   16  src2 nibbles, same packing
//  src_dp         in   12  decimal points, [4i+3:4i] = src i, bit0 = rightmost digit
//  src_pulse      in   3   src i wants PWM brightness pulsing while it owns the display
//  grant          out  3   one-hot current owner; 0 = none
//  sec_dig1       out  4   to subsystem; units of seconds position
//  sec_dig2       out  4   to subsystem
//  min_dig1       out  4   to subsystem
//  min_dig2       out  4   to subsystem
//  decimal_point  out  4   to subsystem
//  triangle_en    out  1   to subsystem; pulse enable of the owner
//  switch_strobe  out  1   one-cycle pulse on every change of owner (incl. to/from none)
// BEHAVIOUR
//  Reset: grant=0, all digit outputs=0, decimal_point=0, triangle_en=0, switch_strobe=0.
//   dwell counter=0, last_owner=2, so src0 wins first round-robin.
//  States:
//   IDLE: grant=0.
//   OWN: one source granted, dwell counter counting down.
//  IDLE -> OWN:
//   Any req bit seen at edge N -> grant valid after edge N.
//   Winner = first requester in order last_owner+1, +2, +3 (mod 3).
//   Counter loaded with DWELL_CYCLES-1; switch_strobe=1 for that cycle.
//  OWN, owner's req drops:
//   Release at next edge regardless of counter.
//   Other requester(s) pending -> grant next round-robin winner directly, no idle cycle.
//   None pending -> IDLE, grant=0.
//  OWN, counter>0, owner still requesting: keep grant; counter decrements by 1 per cycle.
//  OWN, counter==0, owner still requesting:
//   Other requester pending -> hand over to round-robin winner, reload counter.
//   No other requester -> keep owner, reload counter, no strobe.
//  Preemption (PREEMPT_EN=1):
//   req[2] rising while src0/src1 owns -> grant src2 at next edge, counter reloaded.
//   Preempted source is treated as last_owner.
//   src2 is never preempted.
//  Simultaneous owner release and preempt: src2 wins.
//  last_owner updates on every grant.
//  Data path:
//   Outputs registered from the owner's live inputs, selected using the registered grant.
//   Output reflects owner data 1 cycle after a grant change and tracks input changes with 1-cycle latency.
//   grant=0 -> digits=0, decimal_point=0, triangle_en=0.
//  Counter width $clog2(DWELL_CYCLES); never underflows, holds at 0.
//  Async reset mid-dwell clears everything immediately; no strobe on reset.
// TESTING (DWELL_CYCLES=8, PREEMPT_EN=1)
//  1. req=001, src0_digits=16'h1234, src_dp=0:
//     -> grant=001 one edge later; min_dig2..sec_dig1 = 1,2,3,4 one edge after that.
//     -> switch_strobe pulses once.
//  2. req=011 held from reset:
//     -> src0 owns 8 cycles, then src1 owns 8, alternating.
//     -> switch_strobe every 8 cycles; each grant is one-hot.
//  3. src1 owns, req drops to 001 at dwell cycle 3:
//     -> grant=001 at next edge, no idle gap.
//  4. src0 owns, counter=5, req[2] rises with src_pulse[2]=1:
//     -> grant=100 next edge; triangle_en=1 one edge later.
//     -> src2 keeps grant past dwell while src0 requests.
//  5. req=000 while src1 owns:
//     -> grant=000 next edge; all outputs 0 one edge later.
//  6. reset asserted asynchronously during OWN:
//     -> all outputs 0 before next edge.
//     -> after release with req=111, src0 is granted first.

Source files
------------

// File: rtl/display_source_scheduler.sv
// Shares the seven-segment display subsystem among stopwatch, ADC readout and alarm.
// Arbitration is round-robin with a minimum dwell, and the alarm (src2) can optionally preempt.
module display_source_scheduler #(
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter bit          PREEMPT_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] src0_digits,
  input  logic [15:0] src1_digits,
  input  logic [15:0] src2_digits,
  input  logic [11:0] src_dp,
  input  logic [2:0]  src_pulse,
  output logic [2:0]  grant,
  output logic [3:0]  sec_dig1,
  output logic [3:0]  sec_dig2,
  output logic [3:0]  min_dig1,
  output logic [3:0]  min_dig2,
  output logic [3:0]  decimal_point,
  output logic        triangle_en,
  output logic        switch_strobe
);

  localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state_q, state_d;
  logic [2:0]     grant_d;
  logic [1:0]     last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           req2_q;
  logic [2:0]     others;
  logic           preempt;
  logic [15:0]    sel_digits;
  logic [3:0]     sel_dp;
  logic           sel_pulse;

  // First requester after 'last' in cyclic order 0 -> 1 -> 2 -> 0.
  function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
    logic [2:0] pick;
    pick = '0;
    case (last)
      2'd0:    pick = mask[1] ? 3'b010 : mask[2] ? 3'b100 : mask[0] ? 3'b001 : 3'b000;
      2'd1:    pick = mask[2] ? 3'b100 : mask[0] ? 3'b001 : mask[1] ? 3'b010 : 3'b000;
      default: pick = mask[0] ? 3'b001 : mask[1] ? 3'b010 : mask[2] ? 3'b100 : 3'b000;
    endcase
    return pick;
  endfunction

  function automatic logic [1:0] enc(input logic [2:0] g);
    return g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
  endfunction

  assign others  = req & ~grant;
  assign preempt = PREEMPT_EN && req[2] && !req2_q && !grant[2];

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = rr_pick(req, last_q);
          last_d  = enc(grant_d);
          cnt_d   = RELOAD;
          state_d = OWN;
        end
      end
      OWN: begin
        if (preempt) begin
          // last_q keeps the preempted owner so round-robin resumes after it
          grant_d = 3'b100;
          cnt_d   = RELOAD;
        end else if (!(|(req & grant))) begin
          if (|others) begin
            grant_d = rr_pick(others, last_q);
            last_d  = enc(grant_d);
            cnt_d   = RELOAD;
          end else begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if ((|others) && !(PREEMPT_EN && grant[2])) begin
          grant_d = rr_pick(others, last_q);
          last_d  = enc(grant_d);
          cnt_d   = RELOAD;
        end else begin
          cnt_d = RELOAD;
        end
      end
    endcase
  end

  always_comb begin
    sel_digits = '0;
    sel_dp     = '0;
    sel_pulse  = 1'b0;
    case (grant)
      3'b001: begin sel_digits = src0_digits; sel_dp = src_dp[3:0];  sel_pulse = src_pulse[0]; end
      3'b010: begin sel_digits = src1_digits; sel_dp = src_dp[7:4];  sel_pulse = src_pulse[1]; end
      3'b100: begin sel_digits = src2_digits; sel_dp = src_dp[11:8]; sel_pulse = src_pulse[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant         <= '0;
      last_q        <= 2'd2;
      cnt_q         <= '0;
      req2_q        <= 1'b0;
      switch_strobe <= 1'b0;
      min_dig2      <= '0;
      min_dig1      <= '0;
      sec_dig2      <= '0;
      sec_dig1      <= '0;
      decimal_point <= '0;
      triangle_en   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant         <= grant_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      req2_q        <= req[2];
      switch_strobe <= (grant_d != grant);
      {min_dig2, min_dig1, sec_dig2, sec_dig1} <= sel_digits;
      decimal_point <= sel_dp;
      triangle_en   <= sel_pulse;
    end
  end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed bench for display_source_scheduler with DWELL_CYCLES=8, PREEMPT_EN=1.
module tb_display_source_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [15:0] src0_digits, src1_digits, src2_digits;
  logic [11:0] src_dp;
  logic [2:0]  src_pulse;
  logic [2:0]  grant;
  logic [3:0]  sec_dig1, sec_dig2, min_dig1, min_dig2, decimal_point;
  logic        triangle_en, switch_strobe;

  int unsigned tests = 0;
  int unsigned fails = 0;

  display_source_scheduler #(.DWELL_CYCLES(8), .PREEMPT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req),
    .src0_digits(src0_digits), .src1_digits(src1_digits), .src2_digits(src2_digits),
    .src_dp(src_dp), .src_pulse(src_pulse), .grant(grant),
    .sec_dig1(sec_dig1), .sec_dig2(sec_dig2), .min_dig1(min_dig1), .min_dig2(min_dig2),
    .decimal_point(decimal_point), .triangle_en(triangle_en), .switch_strobe(switch_strobe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [15:0] dig, input logic [3:0] dp, input logic tri_en);
    chk({tag, "_digits"}, {min_dig2, min_dig1, sec_dig2, sec_dig1}, dig);
    chk({tag, "_dp"}, {12'h0, decimal_point}, {12'h0, dp});
    chk({tag, "_tri"}, {15'h0, triangle_en}, {15'h0, tri_en});
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] g, input logic s);
    chk({tag, "_grant"}, {13'h0, grant}, {13'h0, g});
    chk({tag, "_strobe"}, {15'h0, switch_strobe}, {15'h0, s});
  endtask

  initial begin
    logic [2:0] exp_g;
    logic       exp_s;
    reset = 1'b1; req = '0; src0_digits = '0; src1_digits = '0; src2_digits = '0;
    src_dp = '0; src_pulse = '0;
    #12;
    chk_grant("reset", 3'b000, 1'b0);
    chk_data("reset", 16'h0000, 4'h0, 1'b0);
    reset = 1'b0;

    // 1: single requester
    req = 3'b001; src0_digits = 16'h1234;
    tick();
    chk_grant("t1_first", 3'b001, 1'b1);
    chk_data("t1_first", 16'h0000, 4'h0, 1'b0);
    tick();
    chk_grant("t1_second", 3'b001, 1'b0);
    chk_data("t1_second", 16'h1234, 4'h0, 1'b0);
    src0_digits = 16'hABCD;
    tick();
    chk_data("t1_track", 16'hABCD, 4'h0, 1'b0);
    req = 3'b000;
    tick();
    chk_grant("t1_release", 3'b000, 1'b1);
    tick();
    chk_data("t1_idle", 16'h0000, 4'h0, 1'b0);

    // 2: alternation with dwell of 8
    reset = 1'b1;
    #2;
    chk_grant("t2_rst", 3'b000, 1'b0);
    reset = 1'b0;
    req = 3'b011;
    tick();
    exp_g = 3'b001;
    chk_grant("t2_start", exp_g, 1'b1);
    for (int i = 1; i <= 24; i++) begin
      tick();
      exp_s = (i % 8 == 0);
      if (exp_s) exp_g = (exp_g == 3'b001) ? 3'b010 : 3'b001;
      chk_grant($sformatf("t2_c%0d", i), exp_g, exp_s);
    end

    // 3: src1 owns, src1 drops mid-dwell
    tick();
    tick();
    req = 3'b001;
    tick();
    chk_grant("t3_handover", 3'b001, 1'b1);

    // 4: preemption by src2 at counter 5
    tick();
    tick();
    req = 3'b101; src_pulse = 3'b100; src2_digits = 16'h9876; src_dp = 12'h500;
    tick();
    chk_grant("t4_preempt", 3'b100, 1'b1);
    tick();
    chk_data("t4_data", 16'h9876, 4'h5, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_grant($sformatf("t4_hold%0d", i), 3'b100, 1'b0);
    end
    req = 3'b001;
    tick();
    chk_grant("t4_back", 3'b001, 1'b1);
    tick();
    chk_data("t4_src0", 16'hABCD, 4'h0, 1'b0);

    // 5: src1 owns then all requests drop
    src1_digits = 16'h5A5A;
    req = 3'b010;
    tick();
    chk_grant("t5_src1", 3'b010, 1'b1);
    tick();
    chk_data("t5_data", 16'h5A5A, 4'h0, 1'b0);
    req = 3'b000;
    tick();
    chk_grant("t5_none", 3'b000, 1'b1);
    tick();
    chk_data("t5_zero", 16'h0000, 4'h0, 1'b0);

    // sole requester keeps display across dwell expiry without strobing
    req = 3'b010;
    tick();
    chk_grant("keep_start", 3'b010, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_grant($sformatf("keep%0d", i), 3'b010, 1'b0);
    end

    // 6: asynchronous reset while owning
    #3;
    reset = 1'b1;
    #1;
    chk_grant("t6_async", 3'b000, 1'b0);
    chk_data("t6_async", 16'h0000, 4'h0, 1'b0);
    #1;
    reset = 1'b0;
    req = 3'b111;
    tick();
    chk_grant("t6_first", 3'b001, 1'b1);
    tick();
    chk_grant("t6_hold", 3'b001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
